// File: rtl/img_pkt_rx.sv
// img_pkt_rx: parses the UART photo-upload stream into a W/H header and
// 12-bit RGB444 pixels, checksummed per block and released only when good.
// Ports:
//   i_clk_sys, i_rst        clock, synchronous active-high reset
//   i_rx_data, i_rx_done    received byte and its one-cycle strobe
//   i_enable                image-receive mode; low forces IDLE
//   o_width, o_height       accepted header dimensions
//   o_pix, o_pix_valid      released pixel {R,G,B} and strobe
//   o_pix_cnt               pixels released in the current frame
//   o_ack_data, o_ack_valid reply byte (0x06 ACK / 0x15 NAK) and strobe
//   o_busy                  frame in progress
//   o_frame_done, o_err     completion and error pulses
module img_pkt_rx #(
  parameter int MAX_W       = 200,
  parameter int MAX_H       = 185,
  parameter int BLK_PIX     = 64,
  parameter int TIMEOUT_CYC = 5000000
) (
  input  logic        i_clk_sys,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_done,
  input  logic        i_enable,
  output logic [7:0]  o_width,
  output logic [7:0]  o_height,
  output logic [11:0] o_pix,
  output logic        o_pix_valid,
  output logic [15:0] o_pix_cnt,
  output logic [7:0]  o_ack_data,
  output logic        o_ack_valid,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic        o_err
);

  localparam int IW = (BLK_PIX > 1) ? $clog2(BLK_PIX) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0] LP_MAX_W = 8'(MAX_W);
  localparam logic [7:0] LP_MAX_H = 8'(MAX_H);
  localparam logic [7:0] LP_BLK = 8'(BLK_PIX);
  localparam logic [TW-1:0] LP_TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0] LP_ACK = 8'h06;
  localparam logic [7:0] LP_NAK = 8'h15;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SYNC0,
    S_SYNC1,
    S_GET_W,
    S_GET_H,
    S_PIX_HI,
    S_PIX_LO,
    S_CHK,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic          r_armed;
  logic [7:0]    r_hold;
  logic          r_hold_vld;
  logic [7:0]    r_wtmp;
  logic [3:0]    r_hi;
  logic [7:0]    r_sum;
  logic [7:0]    r_k;
  logic [7:0]    r_blk_n;
  logic [15:0]   r_wh;
  logic [TW-1:0] r_to;
  logic [11:0]   r_buf [BLK_PIX];

  logic [7:0]  r_width;
  logic [7:0]  r_height;
  logic [11:0] r_pix;
  logic        r_pix_valid;
  logic [15:0] r_pix_cnt;
  logic [7:0]  r_ack_data;
  logic        r_ack_valid;
  logic        r_frame_done;
  logic        r_err;

  logic        w_bv;
  logic [7:0]  w_b;
  logic [15:0] w_rem;
  logic [7:0]  w_n;
  logic        w_timed;
  logic        w_tmo;
  logic        w_hdr_ok;
  logic        w_ack;
  logic        w_nak;
  logic        w_err;
  logic        w_drain;
  logic        w_done;
  logic        w_hdr_acc;
  logic        w_px_wr;
  logic        w_blk_clr;
  logic        w_sum_add;

  // A byte held during DRAIN takes priority over a live strobe.
  assign w_bv = (r_state != S_DRAIN) && (r_hold_vld || i_rx_done);
  assign w_b  = r_hold_vld ? r_hold : i_rx_data;

  // Only the final block of a frame may be short.
  assign w_rem = r_wh - r_pix_cnt;
  assign w_n   = (w_rem >= 16'(BLK_PIX)) ? LP_BLK : w_rem[7:0];

  assign w_timed = (r_state == S_PIX_HI) ||
                   (r_state == S_PIX_LO) ||
                   (r_state == S_CHK);
  assign w_tmo = w_timed && !w_bv && (r_to == LP_TO_LAST);

  assign w_hdr_ok = (r_wtmp != 8'd0) && (r_wtmp <= LP_MAX_W) &&
                    (w_b != 8'd0) && (w_b <= LP_MAX_H);

  always_comb begin
    w_next    = r_state;
    w_ack     = 1'b0;
    w_nak     = 1'b0;
    w_err     = 1'b0;
    w_drain   = 1'b0;
    w_done    = 1'b0;
    w_hdr_acc = 1'b0;
    w_px_wr   = 1'b0;
    w_blk_clr = 1'b0;
    w_sum_add = 1'b0;
    if (!i_enable) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (r_armed) w_next = S_SYNC0;
        end
        S_SYNC0: begin
          if (w_bv && w_b == 8'hA5) w_next = S_SYNC1;
        end
        S_SYNC1: begin
          if (w_bv)
            w_next = (w_b == 8'h5A) ? S_GET_W : S_SYNC0;
        end
        S_GET_W: begin
          if (w_bv) w_next = S_GET_H;
        end
        S_GET_H: begin
          if (w_bv) begin
            if (w_hdr_ok) begin
              w_ack     = 1'b1;
              w_hdr_acc = 1'b1;
              w_next    = S_PIX_HI;
            end else begin
              w_nak  = 1'b1;
              w_err  = 1'b1;
              w_next = S_SYNC0;
            end
          end
        end
        S_PIX_HI: begin
          if (w_tmo) begin
            w_err     = 1'b1;
            w_blk_clr = 1'b1;
          end else if (w_bv) begin
            w_sum_add = 1'b1;
            w_next    = S_PIX_LO;
          end
        end
        S_PIX_LO: begin
          if (w_tmo) begin
            w_err     = 1'b1;
            w_blk_clr = 1'b1;
            w_next    = S_PIX_HI;
          end else if (w_bv) begin
            w_sum_add = 1'b1;
            w_px_wr   = 1'b1;
            w_next = (r_k == w_n - 8'd1) ? S_CHK : S_PIX_HI;
          end
        end
        S_CHK: begin
          if (w_tmo) begin
            w_err     = 1'b1;
            w_blk_clr = 1'b1;
            w_next    = S_PIX_HI;
          end else if (w_bv) begin
            w_blk_clr = 1'b1;
            if (w_b == r_sum) begin
              w_ack  = 1'b1;
              w_next = S_DRAIN;
            end else begin
              w_nak  = 1'b1;
              w_err  = 1'b1;
              w_next = S_PIX_HI;
            end
          end
        end
        S_DRAIN: begin
          w_drain = 1'b1;
          if (r_k == r_blk_n - 8'd1)
            w_next = (r_pix_cnt + 16'd1 == r_wh) ?
                     S_DONE : S_PIX_HI;
        end
        S_DONE: begin
          w_done = 1'b1;
          w_next = S_IDLE;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk_sys) begin
    if (w_px_wr) r_buf[r_k[IW-1:0]] <= {r_hi, w_b};
  end

  always_ff @(posedge i_clk_sys) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_armed      <= 1'b1;
      r_hold       <= 8'd0;
      r_hold_vld   <= 1'b0;
      r_wtmp       <= 8'd0;
      r_hi         <= 4'd0;
      r_sum        <= 8'd0;
      r_k          <= 8'd0;
      r_blk_n      <= 8'd0;
      r_wh         <= 16'd0;
      r_to         <= '0;
      r_width      <= 8'd0;
      r_height     <= 8'd0;
      r_pix        <= 12'd0;
      r_pix_valid  <= 1'b0;
      r_pix_cnt    <= 16'd0;
      r_ack_data   <= 8'd0;
      r_ack_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_ack_valid  <= w_ack | w_nak;
      r_err        <= w_err;
      r_frame_done <= w_done;
      r_pix_valid  <= w_drain;

      // Re-entry after DONE needs enable to have been seen low.
      if (!i_enable) r_armed <= 1'b1;
      else if (w_done) r_armed <= 1'b0;

      if (!i_enable || r_state == S_IDLE ||
          r_state == S_DONE) begin
        r_hold_vld <= 1'b0;
      end else if (r_state == S_DRAIN) begin
        if (i_rx_done) begin
          r_hold     <= i_rx_data;
          r_hold_vld <= 1'b1;
        end
      end else if (r_hold_vld) begin
        if (i_rx_done) r_hold <= i_rx_data;
        else r_hold_vld <= 1'b0;
      end

      if (w_ack) r_ack_data <= LP_ACK;
      else if (w_nak) r_ack_data <= LP_NAK;

      if (r_state == S_GET_W && w_bv) r_wtmp <= w_b;

      if (w_hdr_acc) begin
        r_width   <= r_wtmp;
        r_height  <= w_b;
        r_wh      <= 16'(r_wtmp) * 16'(w_b);
        r_pix_cnt <= 16'd0;
      end

      if (r_state == S_PIX_HI && w_sum_add) r_hi <= w_b[3:0];

      if (w_blk_clr || w_hdr_acc || !i_enable) begin
        r_sum <= 8'd0;
        r_k   <= 8'd0;
      end else begin
        if (w_sum_add) r_sum <= r_sum + w_b;
        if (w_px_wr) r_k <= r_k + 8'd1;
        if (w_drain) begin
          r_pix     <= r_buf[r_k[IW-1:0]];
          r_pix_cnt <= r_pix_cnt + 16'd1;
          r_k <= (r_k == r_blk_n - 8'd1) ? 8'd0 : r_k + 8'd1;
        end
      end

      // Block size is frozen while draining since o_pix_cnt moves.
      if (r_state != S_DRAIN) r_blk_n <= w_n;

      if (w_timed && !w_bv && !w_tmo) r_to <= r_to + 1'b1;
      else r_to <= '0;
    end
  end

  assign o_width      = r_width;
  assign o_height     = r_height;
  assign o_pix        = r_pix;
  assign o_pix_valid  = r_pix_valid;
  assign o_pix_cnt    = r_pix_cnt;
  assign o_ack_data   = r_ack_data;
  assign o_ack_valid  = r_ack_valid;
  assign o_frame_done = r_frame_done;
  assign o_err        = r_err;
  assign o_busy       = (r_state != S_IDLE) && (r_state != S_DONE);

endmodule

// File: doc/img_pkt_rx.md
# img_pkt_rx

Image packet receiver between `uart_rx` and the frame RAM writer. It parses the UART byte stream of a photo upload into a width/height header and 12-bit RGB444 pixels. Pixels arrive in fixed-size blocks, each protected by an 8-bit checksum, and are buffered per block. A block's pixels are released downstream only after its checksum passes; a failing block is discarded so the sender can retransmit it. ACK/NAK bytes are produced for the UART transmit path.

## Interface
Parameters:
- `MAX_W`, 200, largest accepted image width in pixels
- `MAX_H`, 185, largest accepted image height in pixels
- `BLK_PIX`, 64, pixels per checksum block (1..255)
- `TIMEOUT_CYC`, 5000000, idle cycles allowed between bytes inside a frame (100 ms at 50 MHz)

Ports:
- `i_clk_sys`  in  1  system clock, 50 MHz
- `i_rst`  in  1  synchronous reset, active-high
- `i_rx_data`  in  8  received UART byte
- `i_rx_done`  in  1  one-cycle strobe: `i_rx_data` valid
- `i_enable`  in  1  image-receive mode from the state machine; low forces IDLE
- `o_width`  out  8  accepted image width
- `o_height`  out  8  accepted image height
- `o_pix`  out  12  pixel {R,G,B} 4 bits each
- `o_pix_valid`  out  1  one-cycle strobe per released pixel
- `o_pix_cnt`  out  16  pixels released in the current frame
- `o_ack_data`  out  8  reply byte: 0x06 ACK, 0x15 NAK
- `o_ack_valid`  out  1  one-cycle strobe for `o_ack_data`
- `o_busy`  out  1  high from SYNC0 until DONE or abort
- `o_frame_done`  out  1  one-cycle pulse after the last pixel of the frame is released
- `o_err`  out  1  one-cycle pulse on a bad header, checksum failure or timeout

## Operation
- Byte protocol: 0xA5, 0x5A, W, H, then per block {hi, lo} per pixel followed by one checksum byte.
  - Pixel value = {hi[3:0], lo}. hi[7:4] is ignored but still summed.
  - Checksum = sum mod 256 of the 2·n pixel bytes of the block.
- Block size: n = `BLK_PIX` for every block except the last, which carries W·H mod `BLK_PIX` pixels when that is nonzero. W·H is computed once at header time into a 16-bit register.
- States: IDLE → SYNC0 → SYNC1 → GET_W → GET_H → PIX_HI ↔ PIX_LO → CHK → DRAIN → (PIX_HI | DONE).
- IDLE: leaves to SYNC0 when `i_enable` is high.
- SYNC0: waits for 0xA5; any other byte is ignored.
- SYNC1: on 0x5A goes to GET_W; any other byte returns to SYNC0.
- GET_W / GET_H: latch the width and height bytes.
- GET_H checks 1 ≤ W ≤ `MAX_W` and 1 ≤ H ≤ `MAX_H`.
  - Pass: send ACK, clear `o_pix_cnt`, go to PIX_HI.
  - Fail: send NAK, pulse `o_err`, return to SYNC0. `o_width`/`o_height` keep their previous values.
- PIX_HI / PIX_LO: each byte is added to the running sum. The pixel is written to buffer entry k (BLK_PIX×12 registers). After the n-th pixel, go to CHK.
- CHK: compare the received byte with the running sum.
  - Match: send ACK, go to DRAIN.
  - Mismatch: send NAK, pulse `o_err`, clear the sum and k, return to PIX_HI for the same block. The frame position does not advance.
- DRAIN: release entries 0..n−1 on consecutive cycles, one per cycle, incrementing `o_pix_cnt`. Then go to PIX_HI, or to DONE if `o_pix_cnt` = W·H.
- DONE: pulse `o_frame_done`, drop `o_busy`, return to IDLE. Re-entry to SYNC0 requires `i_enable` to be low for at least one cycle first.
- A byte strobed during DRAIN is held in a one-deep register and processed in the cycle after DRAIN ends. A second byte in that window overwrites the held byte. This cannot happen at 9600 baud.
- Timeout: in PIX_HI, PIX_LO or CHK, `TIMEOUT_CYC` cycles without `i_rx_done` cause:
  - `o_err` pulse, no reply byte;
  - the current block is discarded and reception restarts at PIX_HI.
  - The counter reloads on every strobe.
- `i_enable` low in any state: go to IDLE on the next cycle. The buffer is discarded, no pulses are issued, and `o_busy` goes to 0.

## Timing
- Reset values: all strobes 0, `o_busy` 0, `o_width`/`o_height`/`o_pix`/`o_pix_cnt` 0, `o_ack_data` 0x00, state IDLE.
- `o_ack_valid` and `o_err` assert one cycle after the `i_rx_done` of the triggering byte. `o_ack_data` is stable in that cycle and holds until the next reply.
- First `o_pix_valid` occurs 2 cycles after the checksum byte's `i_rx_done`. Block release takes exactly n cycles.
- `o_frame_done` occurs the cycle after the last `o_pix_valid`.
- `o_pix_cnt` updates in the same cycle as `o_pix_valid`.
- Simultaneous `i_rst` and `i_enable`: reset wins.

## Test plan
- Header 0xA5 0x5A 0x04 0x02, then one block of 8 pixels 0x0F,0xFF × 8 with checksum 0x70 → ACK, ACK; 8 consecutive `o_pix_valid` with `o_pix`=0xFFF; `o_pix_cnt`=8; `o_frame_done` pulses.
- Same frame with a bad checksum 0x71 → NAK, `o_err` pulses, no pixel strobes; retransmitting the block with 0x70 → 8 pixels and `o_frame_done`.
- W=201, H=10 → NAK and `o_err`; state back in SYNC0; `o_busy` stays 1.
- `BLK_PIX`=64, W=10, H=10 → blocks of 64 and 36 pixels, three ACKs, `o_pix_cnt`=100 at `o_frame_done`.
- `TIMEOUT_CYC`=100; stop after 3 bytes of a block → `o_err` at cycle 100; a full block sent afterwards is accepted.
- Drop `i_enable` mid-block → `o_busy` 0 next cycle; no strobes. Reset asserted mid-DRAIN → all outputs return to their reset values the next cycle.
